// File: rtl/rf_sequencer.sv
// Multicycle sequencer for the register-file/ALU datapath: accepts one instruction
// per valid/ready handshake and drives RF, ALU and memory-request controls.
module rf_sequencer #(
    parameter int N           = 8,
    parameter int addressBits = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [4+3*addressBits-1:0] instr,
    input  logic [N-1:0]              imm,
    input  logic                      mem_ack,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [1:0]                selectSource,
    output logic [addressBits-1:0]    writeAddress,
    output logic                      write_en,
    output logic [addressBits-1:0]    readAddressA,
    output logic [addressBits-1:0]    readAddressB,
    output logic                      selectDestinationA,
    output logic                      selectDestinationB,
    output logic [1:0]                alu_op,
    output logic [N-1:0]              imm_out,
    output logic                      busy,
    output logic                      halted,
    output logic                      err,
    output logic [15:0]               retired_count
);

    localparam int IW = 4 + 3 * addressBits;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_MOV  = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;
    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_ST   = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_HALTED} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_instr_q;
    logic [N-1:0]     r_imm;
    logic [CW-1:0]    r_wait;
    logic             r_err;
    logic [15:0]      r_retired;

    logic [3:0]             w_in_op;
    logic [3:0]             w_op;
    logic [addressBits-1:0] w_rd;
    logic [addressBits-1:0] w_ra;
    logic [addressBits-1:0] w_rb;
    logic                   w_rd_writable;

    assign w_in_op = instr[IW-1 -: 4];
    assign w_op    = r_instr_q[IW-1 -: 4];
    assign w_rd    = r_instr_q[3*addressBits-1 -: addressBits];
    assign w_ra    = r_instr_q[2*addressBits-1 -: addressBits];
    assign w_rb    = r_instr_q[addressBits-1:0];
    // RF registers 0 and 1 are hard-wired constants and must never be written.
    assign w_rd_writable = (w_rd > addressBits'(1));

    assign instr_ready   = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign halted        = (r_state == S_HALTED);
    assign err           = r_err;
    assign imm_out       = r_imm;
    assign retired_count = r_retired;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_instr_q <= '0;
            r_imm     <= '0;
            r_wait    <= '0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr_q <= instr;
                        r_imm     <= imm;
                        r_wait    <= '0;
                        case (w_in_op)
                            OP_NOP: r_retired <= r_retired + 16'd1;
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_LDI: r_state <= S_EXEC;
                            OP_LD, OP_ST: r_state <= S_MEM;
                            OP_HALT: begin
                                r_state   <= S_HALTED;
                                r_retired <= r_retired + 16'd1;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                S_EXEC: begin
                    r_state   <= S_IDLE;
                    r_retired <= r_retired + 16'd1;
                end
                S_MEM: begin
                    // An ack on the final wait cycle still completes the access.
                    if (mem_ack) begin
                        r_state   <= S_IDLE;
                        r_retired <= r_retired + 16'd1;
                    end else if (r_wait == CW'(TIMEOUT - 1)) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        selectSource       = 2'd0;
        writeAddress       = '0;
        write_en           = 1'b0;
        readAddressA       = '0;
        readAddressB       = '0;
        selectDestinationA = 1'b0;
        selectDestinationB = 1'b0;
        alu_op             = 2'b00;
        case (r_state)
            S_EXEC: begin
                writeAddress = w_rd;
                write_en     = w_rd_writable;
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        readAddressA = w_ra;
                        readAddressB = w_rb;
                        alu_op       = w_op[1:0] - 2'd1;
                    end
                    OP_MOV:  readAddressA = w_ra;
                    OP_LDI:  selectSource = 2'd2;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req            = 1'b1;
                readAddressA       = w_ra;
                selectDestinationA = 1'b1;
                if (w_op == OP_ST) begin
                    mem_we             = 1'b1;
                    readAddressB       = w_rb;
                    selectDestinationB = 1'b1;
                end else if (mem_ack) begin
                    selectSource = 2'd1;
                    writeAddress = w_rd;
                    write_en     = w_rd_writable && !rst;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Randomised self-checking bench for rf_sequencer; expectations come from a
// per-instruction behavioural model of the sequencing rules.
module tb_rf_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [12:0] instr;
    logic [7:0]  imm;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  selectSource;
    logic [2:0]  writeAddress;
    logic        write_en;
    logic [2:0]  readAddressA;
    logic [2:0]  readAddressB;
    logic        selectDestinationA;
    logic        selectDestinationB;
    logic [1:0]  alu_op;
    logic [7:0]  imm_out;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] retired_count;

    rf_sequencer #(.N(8), .addressBits(3), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr              (instr),
        .imm                (imm),
        .mem_ack            (mem_ack),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .selectSource       (selectSource),
        .writeAddress       (writeAddress),
        .write_en           (write_en),
        .readAddressA       (readAddressA),
        .readAddressB       (readAddressB),
        .selectDestinationA (selectDestinationA),
        .selectDestinationB (selectDestinationB),
        .alu_op             (alu_op),
        .imm_out            (imm_out),
        .busy               (busy),
        .halted             (halted),
        .err                (err),
        .retired_count      (retired_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_ret  = '0;
    logic [7:0]  exp_imm  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Runs one instruction starting at a negedge with the sequencer idle and
    // returns at a negedge with it idle again (or halted). ack_at < 0 or
    // >= TIMEOUT means memory never acknowledges.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, input logic [7:0] imm_v, input int ack_at);
        bit is_exec  = (op >= 4'd1 && op <= 4'd6);
        bit is_mem   = (op == 4'd7 || op == 4'd8);
        bit is_halt  = (op == 4'd15);
        bit is_nop   = (op == 4'd0);
        bit is_alu4  = (op >= 4'd1 && op <= 4'd4);
        bit is_ld    = (op == 4'd7);
        bit wr_ok    = (rd >= 3'd2);
        bit timed_out;

        instr_valid = 1'b1;
        instr       = {op, rd, ra, rb};
        imm         = imm_v;
        mem_ack     = 1'($urandom);
        #1;
        check("accept_ready", instr_ready, 1);
        check("accept_we", write_en, 0);
        check("accept_memreq", mem_req, 0);
        @(negedge clk);
        exp_imm = imm_v;
        if (is_exec || is_mem || is_halt) begin
            instr_valid = 1'($urandom);
            instr       = 13'($urandom);
            imm         = 8'($urandom);
        end else begin
            instr_valid = 1'b0;
        end
        mem_ack = is_mem ? 1'b0 : 1'($urandom);
        #1;
        check("imm_latched", imm_out, exp_imm);

        if (is_nop) begin
            exp_ret++;
            check("nop_ready", instr_ready, 1);
            check("nop_retired", retired_count, exp_ret);
            check("nop_err", err, 0);
        end else if (is_halt) begin
            exp_ret++;
            check("halt_flag", halted, 1);
            check("halt_ready", instr_ready, 0);
            check("halt_retired", retired_count, exp_ret);
        end else if (is_exec) begin
            check("exec_ready", instr_ready, 0);
            check("exec_busy", busy, 1);
            check("exec_we", write_en, wr_ok);
            check("exec_waddr", writeAddress, rd);
            check("exec_src", selectSource, (op == 4'd6) ? 2 : 0);
            check("exec_aluop", alu_op, is_alu4 ? (op - 4'd1) : 0);
            check("exec_ra", readAddressA, (op == 4'd6) ? 3'd0 : ra);
            check("exec_rb", readAddressB, is_alu4 ? rb : 3'd0);
            check("exec_dest", {selectDestinationA, selectDestinationB}, 0);
            check("exec_memreq", mem_req, 0);
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ack     = 1'b0;
            #1;
            exp_ret++;
            check("exec_done_ready", instr_ready, 1);
            check("exec_done_retired", retired_count, exp_ret);
            check("exec_done_we", write_en, 0);
        end else if (is_mem) begin
            timed_out = 1'b1;
            for (int k = 0; k < TIMEOUT; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    instr_valid = 1'($urandom);
                    instr       = 13'($urandom);
                end
                mem_ack = (k == ack_at);
                #1;
                check("mem_req", mem_req, 1);
                check("mem_we", mem_we, !is_ld);
                check("mem_ra", readAddressA, ra);
                check("mem_rb", readAddressB, is_ld ? 3'd0 : rb);
                check("mem_dest", {selectDestinationA, selectDestinationB}, is_ld ? 2'b10 : 2'b11);
                check("mem_we_rf", write_en, is_ld && mem_ack && wr_ok);
                check("mem_src", selectSource, (is_ld && mem_ack) ? 1 : 0);
                if (is_ld && mem_ack) check("mem_waddr", writeAddress, rd);
                if (mem_ack) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ack     = 1'b0;
            #1;
            if (!timed_out) exp_ret++;
            check("mem_done_req", mem_req, 0);
            check("mem_done_ready", instr_ready, 1);
            check("mem_done_err", err, timed_out);
            check("mem_done_retired", retired_count, exp_ret);
            check("mem_done_we", write_en, 0);
            if (timed_out) begin
                @(negedge clk);
                #1;
                check("timeout_err_pulse", err, 0);
            end
        end else begin
            check("illegal_err", err, 1);
            check("illegal_ready", instr_ready, 1);
            check("illegal_retired", retired_count, exp_ret);
            @(negedge clk);
            #1;
            check("illegal_err_pulse", err, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        exp_ret     = '0;
        exp_imm     = '0;
        #1;
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_retired", retired_count, 0);
        check("rst_imm", imm_out, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_we", write_en, 0);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        imm         = '0;
        mem_ack     = 1'b0;
        @(negedge clk);
        do_reset();

        run_instr(4'd1, 3'd2, 3'd1, 3'd1, 8'h00, -1);
        check("first_add_retired", retired_count, 1);
        run_instr(4'd6, 3'd3, 3'd0, 3'd0, 8'h5A, -1);
        run_instr(4'd5, 3'd4, 3'd3, 3'd6, 8'h11, -1);
        run_instr(4'd7, 3'd5, 3'd3, 3'd0, 8'h22, 4);
        run_instr(4'd8, 3'd0, 3'd2, 3'd3, 8'h33, -1);
        run_instr(4'd8, 3'd0, 3'd2, 3'd3, 8'h44, TIMEOUT - 1);
        run_instr(4'hB, 3'd2, 3'd2, 3'd2, 8'h55, -1);
        run_instr(4'd1, 3'd1, 3'd2, 3'd3, 8'h66, -1);

        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 13'h0;
        imm         = 8'h77;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("nop_b2b_ready", instr_ready, 1);
            @(negedge clk);
            exp_ret++;
            #1;
            check("nop_b2b_count", retired_count, exp_ret);
        end
        instr_valid = 1'b0;
        exp_imm     = 8'h77;
        check("nop_b2b_imm", imm_out, exp_imm);
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            run_instr(op, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
                      int'($urandom_range(0, TIMEOUT + 4)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        instr_valid = 1'b1;
        instr       = {4'd7, 3'd5, 3'd3, 3'd0};
        imm         = 8'h99;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("ld_wait_req", mem_req, 1);
        do_reset();

        run_instr(4'd2, 3'd6, 3'd4, 3'd5, 8'hA5, -1);
        run_instr(4'd15, 3'd0, 3'd0, 3'd0, 8'hC3, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            instr       = {4'd1, 3'd2, 3'd1, 3'd1};
            mem_ack     = 1'($urandom);
            #1;
            check("halt_hold", halted, 1);
            check("halt_not_ready", instr_ready, 0);
            check("halt_no_we", write_en, 0);
            check("halt_retired", retired_count, exp_ret);
        end
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
